// File: rtl/pll_rst_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pll_rst_pkg: shared types and helpers for the PLL reset sequencer (rev 1.0)
// -----------------------------------------------------------------------------
package pll_rst_pkg;

  localparam int RELOCK_W = 8;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sync_2ff: single-bit two-flop synchronizer, synchronous reset to 0 (rev 1.0)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_reset_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pll_reset_ctrl: PLL reset pulse, lock filtering, retry and relock sequencer (rev 1.0)
// -----------------------------------------------------------------------------
module pll_reset_ctrl
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                refclk_i,
  input  logic                rst_i,
  input  logic                locked_i,
  output logic                pll_rst_o,
  output logic                sys_rst_o,
  output logic                ready_o,
  output logic                lock_fail_o,
  output logic [RELOCK_W-1:0] relock_count_o
);

  localparam int CNT_W = width_for(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES));
  localparam int RET_W = width_for(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RET_W-1:0] RET_LIMIT    = RET_W'(MAX_RETRIES);

  logic                locked_s;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RET_W-1:0]    retries_q, retries_d;
  logic [RET_W-1:0]    retries_inc;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                pll_rst_q, pll_rst_d;
  logic                sys_rst_q, sys_rst_d;
  logic                ready_q, ready_d;
  logic                lock_fail_q, lock_fail_d;

  sync_2ff u_lock_sync (
    .clk_i (refclk_i),
    .rst_i (rst_i),
    .d_i   (locked_i),
    .q_o   (locked_s)
  );

  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retries_q   <= '0;
      relock_q    <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      relock_q    <= relock_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      lock_fail_q <= lock_fail_d;
    end
  end

  assign retries_inc = retries_q + RET_W'(1);

  // A lock change always wins over a counter expiring in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    relock_d  = relock_q;
    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retries_d = retries_inc;
          state_d   = (retries_inc == RET_LIMIT) ? FAIL : RESET_PLL;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = RUN;
          cnt_d     = '0;
          retries_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
          if (relock_q != '1) begin
            relock_d = relock_q + RELOCK_W'(1);
          end
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // Decoding the next state keeps the flopped outputs aligned with state_q.
  always_comb begin
    pll_rst_d   = 1'b0;
    sys_rst_d   = 1'b1;
    ready_d     = 1'b0;
    lock_fail_d = 1'b0;
    unique case (state_d)
      RESET_PLL: pll_rst_d = 1'b1;
      WAIT_LOCK: pll_rst_d = 1'b0;
      STABLE:    pll_rst_d = 1'b0;
      RUN: begin
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      FAIL: begin
        pll_rst_d   = 1'b1;
        lock_fail_d = 1'b1;
      end
      default: pll_rst_d = 1'b1;
    endcase
  end

  assign pll_rst_o      = pll_rst_q;
  assign sys_rst_o      = sys_rst_q;
  assign ready_o        = ready_q;
  assign lock_fail_o    = lock_fail_q;
  assign relock_count_o = relock_q;

endmodule
`default_nettype wire

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
- Reset and lock sequencer for the system PLL. Runs on the free-running 50 MHz reference clock.
- Drives the PLL `rst` input and consumes the PLL `locked` output.
- Filters lock with a stability window, retries on lock timeout, and re-resets the PLL on loss of lock.
- Produces `sys_rst` and `ready` for the logic clocked by the PLL output. The 200 MHz domain re-synchronizes `sys_rst` locally.

Parameters:
- PLL_RST_CYCLES, 16: refclk cycles for which `pll_rst` is held high per PLL reset pulse (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synchronized `locked` required before release (>=1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a retry (>=2).
- MAX_RETRIES, 3: number of timeouts that forces FAIL (>=1).
- CNT_W, derived as clog2 of the maximum of the three cycle parameters: shared counter width. Not overridden.

Ports:
- refclk  in  1: reference clock, 50 MHz, free-running.
- rst  in  1: synchronous, active-high reset in the refclk domain.
- locked  in  1: PLL lock indicator, asynchronous to refclk.
- pll_rst  out  1: reset to the PLL, registered.
- sys_rst  out  1: system reset request, active-high, registered.
- ready  out  1: high only in RUN, registered.
- lock_fail  out  1: sticky; high in FAIL.
- relock_count  out  8: saturating count of lock losses seen in RUN.

Behaviour:
- **Clock and reset:** single clock `refclk`. `rst` is synchronous and active-high.
- **Reset values** (cycle after `rst` is sampled high):
  - state = RESET_PLL, cnt = 0, retries = 0, relock_count = 0.
  - Synchronizer flops = 0.
  - pll_rst = 1, sys_rst = 1, ready = 0, lock_fail = 0.
- **Lock synchronization:** `locked` passes through a 2-flop synchronizer to give `locked_s`. Latency is 2 cycles. Only `locked_s` is used.
- **Registered outputs:** outputs are flops loaded from a decode of the next state. They equal a Moore decode of the current state, with no glitches and no added latency.
- **RESET_PLL:**
  - Outputs: pll_rst = 1, sys_rst = 1.
  - cnt increments each cycle. At cnt == PLL_RST_CYCLES-1, go to WAIT_LOCK with cnt = 0.
- **WAIT_LOCK:**
  - Outputs: pll_rst = 0, sys_rst = 1.
  - If `locked_s` = 1, go to STABLE with cnt = 0.
  - Otherwise, at cnt == LOCK_TIMEOUT_CYCLES-1, increment retries. If the new value equals MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL. cnt = 0 in both cases.
  - Otherwise cnt increments.
- **STABLE:**
  - Outputs: pll_rst = 0, sys_rst = 1.
  - If `locked_s` = 0, go to WAIT_LOCK with cnt = 0. This is a glitch: retries is unchanged.
  - If `locked_s` = 1 at cnt == LOCK_STABLE_CYCLES-1, go to RUN.
  - Otherwise cnt increments.
- **RUN:**
  - Outputs: pll_rst = 0, sys_rst = 0, ready = 1.
  - retries is cleared on entry.
  - If `locked_s` = 0, go to RESET_PLL with cnt = 0 and increment relock_count (saturates at 255). sys_rst and pll_rst go high in the first cycle of RESET_PLL.
- **FAIL:**
  - Outputs: pll_rst = 1, sys_rst = 1, ready = 0, lock_fail = 1.
  - Terminal state; only `rst` exits.
- **Invariants:**
  - `ready` implies `!sys_rst`.
  - `ready` and `lock_fail` are never both high.
  - cnt never exceeds the active limit.
- **Reset mid-operation:** `rst` in any state returns to the reset values on the next edge. Counters are cleared and lock_fail is cleared.
- **Simultaneous events:** `locked_s` rising on the WAIT_LOCK timeout cycle takes priority, so the block goes to STABLE. `locked_s` falling on the final STABLE cycle takes priority, so the block goes to WAIT_LOCK.

Decomposition:
- Package `pll_rst_pkg` holds:
  - the state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL);
  - the clog2-based width function;
  - the RELOCK_W = 8 constant.
- Sub-module `sync_2ff`: a single-bit 2-flop synchronizer with synchronous reset to 0, reusable elsewhere.
- State machine, counter, retry and relock logic stay in `pll_reset_ctrl`.

Test Plan:
- Test parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2. "Cycle 0" is the first edge with `rst` = 0.
- Nominal lock: `locked` high from cycle 6 -> pll_rst = 1 in cycles 0-3 and 0 from cycle 4; ready = 1 and sys_rst = 0 from cycle 17.
- Timeout to fail: `locked` held 0 -> pll_rst pulses in cycles 0-3 and again in 36-39; lock_fail = 1, pll_rst = 1 and sys_rst = 1 from cycle 72 onward; ready stays 0.
- Glitch in STABLE: `locked` high from cycle 6, then 0 for one cycle at cycle 12 -> return to WAIT_LOCK, then a fresh 8-cycle window; ready rises 8 or more cycles after `locked_s` recovers; retries unchanged; pll_rst never re-pulses.
- Loss of lock in RUN: from RUN, drop `locked` for 3 cycles -> 2 cycles after `locked` falls, sys_rst = 1 and ready = 0; pll_rst high for 4 cycles; relock_count = 1; RUN re-entered after re-lock. Repeat 300 times -> relock_count saturates at 255.
- Reset mid-STABLE and in FAIL: assert `rst` for 1 cycle -> the next cycle shows all reset values (lock_fail = 0, relock_count = 0, pll_rst = 1) and the sequence restarts.
